// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant searching upward from ptr, plus the pointer that follows the winner
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] nxt
);
  logic [PW-1:0] idx;
  always_comb begin
    gnt = '0;
    nxt = ptr;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % N);
      if (req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
        nxt = PW'((int'(ptr) + i + 1) % N);
      end
    end
  end
endmodule

// File: rtl/dpram_rr_ctrl.sv
// dpram_rr_ctrl: round-robin write/read arbitration, read response routing and clear engine for a shared dpram
module dpram_rr_ctrl #(
  parameter int NREQ  = 4,
  parameter int MEMD  = 16,
  parameter int DATAW = 32,
  parameter int AW    = $clog2(MEMD)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic                  clr_busy,
  input  logic [NREQ-1:0]       wr_vld,
  input  logic [NREQ*AW-1:0]    wr_addr,
  input  logic [NREQ*DATAW-1:0] wr_data,
  output logic [NREQ-1:0]       wr_gnt,
  input  logic [NREQ-1:0]       rd_vld,
  input  logic [NREQ*AW-1:0]    rd_addr,
  output logic [NREQ-1:0]       rd_gnt,
  output logic [NREQ-1:0]       rsp_vld,
  output logic [DATAW-1:0]      rsp_data,
  output logic                  mem_wenb,
  output logic [AW-1:0]         mem_waddr,
  output logic [DATAW-1:0]      mem_wdata,
  output logic [AW-1:0]         mem_raddr,
  input  logic [DATAW-1:0]      mem_rdata
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nxt;
  logic arb_en, clr_last;
  logic [PW-1:0] wptr, rptr, wptr_nxt, rptr_nxt;
  logic [AW-1:0] clr_cnt, raddr_q, wa_mux, ra_mux;
  logic [DATAW-1:0] wd_mux;
  // a clear request in IDLE wins over every request pending that cycle
  assign arb_en = state == IDLE && !clr_req;
  rr_arbiter #(.N(NREQ), .PW(PW)) u_warb (
    .req(wr_vld & {NREQ{arb_en}}), .ptr(wptr), .gnt(wr_gnt), .nxt(wptr_nxt)
  );
  rr_arbiter #(.N(NREQ), .PW(PW)) u_rarb (
    .req(rd_vld & {NREQ{arb_en}}), .ptr(rptr), .gnt(rd_gnt), .nxt(rptr_nxt)
  );
  always_comb begin
    wa_mux = '0;
    wd_mux = '0;
    ra_mux = '0;
    for (int i = 0; i < NREQ; i++) begin
      wa_mux |= wr_addr[i*AW +: AW] & {AW{wr_gnt[i]}};
      wd_mux |= wr_data[i*DATAW +: DATAW] & {DATAW{wr_gnt[i]}};
      ra_mux |= rd_addr[i*AW +: AW] & {AW{rd_gnt[i]}};
    end
  end
  assign clr_last = clr_cnt == AW'(MEMD - 1);
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (clr_req ? CLEAR : IDLE) : (clr_last ? IDLE : CLEAR);
  end
  assign clr_busy  = state == CLEAR;
  assign mem_wenb  = clr_busy | (|wr_gnt);
  assign mem_waddr = clr_busy ? clr_cnt : wa_mux;
  assign mem_wdata = clr_busy ? '0 : wd_mux;
  assign mem_raddr = |rd_gnt ? ra_mux : raddr_q;
  assign rsp_data  = mem_rdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      raddr_q <= '0;
      rsp_vld <= '0;
      clr_cnt <= '0;
    end else begin
      wptr    <= wptr_nxt;
      rptr    <= rptr_nxt;
      raddr_q <= mem_raddr;
      rsp_vld <= rd_gnt;
      clr_cnt <= clr_busy ? (clr_last ? '0 : clr_cnt + 1'b1) : clr_cnt;
    end
endmodule

// File: tb/tb_dpram_rr_ctrl.sv
// tb_dpram_rr_ctrl: directed stimulus, behavioural model of arbitration/clear/memory, literal spot checks
module tb_dpram_rr_ctrl;
  localparam int NREQ = 4, MEMD = 16, DATAW = 32, AW = 4;
  logic clk = 0, rst_n = 0, clr_req = 0, clr_busy;
  logic [NREQ-1:0] wr_vld = 0, rd_vld = 0, wr_gnt, rd_gnt, rsp_vld;
  logic [NREQ*AW-1:0] wr_addr = 0, rd_addr = 0;
  logic [NREQ*DATAW-1:0] wr_data = 0;
  logic [DATAW-1:0] rsp_data, mem_wdata, mem_rdata;
  logic mem_wenb;
  logic [AW-1:0] mem_waddr, mem_raddr;
  int total = 0, bad = 0;

  dpram_rr_ctrl #(.NREQ(NREQ), .MEMD(MEMD), .DATAW(DATAW)) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(clr_busy),
    .wr_vld(wr_vld), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_vld(rd_vld), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data),
    .mem_wenb(mem_wenb), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // dual-port RAM with registered read and write-to-read bypass
  logic [DATAW-1:0] dmem [MEMD];
  always @(posedge clk) begin
    if (mem_wenb) dmem[mem_waddr] <= mem_wdata;
    mem_rdata <= (mem_wenb && mem_waddr == mem_raddr) ? mem_wdata : dmem[mem_raddr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // reference model: expected memory, pointers, clear progress, pending response
  logic [DATAW-1:0] mm [MEMD];
  int m_clear = 0, m_cnt = 0, wp = 0, rp = 0, m_raddr = 0;
  logic [NREQ-1:0] m_rspv = 0;
  logic [DATAW-1:0] m_rdat = 0;
  always @(negedge clk) begin : model
    int wk, rk, ewa, era;
    logic [DATAW-1:0] ewd;
    logic ewen;
    if (!rst_n) begin
      m_clear = 0; m_cnt = 0; wp = 0; rp = 0; m_raddr = 0; m_rspv = 0;
      chk("m_rst_busy", clr_busy, 0);
      chk("m_rst_rspv", rsp_vld, 0);
    end else begin
      wk = -1;
      rk = -1;
      if (m_clear == 0 && !clr_req)
        for (int i = 0; i < NREQ; i++) begin
          if (wk < 0 && wr_vld[(wp + i) % NREQ]) wk = (wp + i) % NREQ;
          if (rk < 0 && rd_vld[(rp + i) % NREQ]) rk = (rp + i) % NREQ;
        end
      ewen = m_clear != 0 || wk >= 0;
      ewa = m_clear != 0 ? m_cnt : (wk >= 0 ? int'(wr_addr[wk*AW +: AW]) : 0);
      ewd = (m_clear == 0 && wk >= 0) ? wr_data[wk*DATAW +: DATAW] : '0;
      era = rk >= 0 ? int'(rd_addr[rk*AW +: AW]) : m_raddr;
      chk("m_busy", clr_busy, m_clear != 0);
      chk("m_wgnt", wr_gnt, wk >= 0 ? (1 << wk) : 0);
      chk("m_rgnt", rd_gnt, rk >= 0 ? (1 << rk) : 0);
      chk("m_wen", mem_wenb, ewen);
      chk("m_waddr", mem_waddr, ewa);
      chk("m_wdata", mem_wdata, ewd);
      chk("m_raddr", mem_raddr, era);
      chk("m_rspv", rsp_vld, m_rspv);
      if (m_rspv != 0) chk("m_rdata", rsp_data, m_rdat);
      if (rk >= 0) begin
        m_rdat = (ewen && ewa == era) ? ewd : mm[era];
        m_rspv = NREQ'(1 << rk);
        rp = (rk + 1) % NREQ;
        m_raddr = era;
      end else m_rspv = 0;
      if (ewen) mm[ewa] = ewd;
      if (wk >= 0) wp = (wk + 1) % NREQ;
      if (m_clear != 0) begin
        if (m_cnt == MEMD - 1) begin m_clear = 0; m_cnt = 0; end
        else m_cnt++;
      end else if (clr_req) m_clear = 1;
    end
  end

  function automatic int oh2i(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return 15;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse;
    clr_req = 1;
    tick();
    clr_req = 0;
  endtask

  // returns at the first negedge where clr_busy is low again
  task automatic wait_clear(output int n);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (clr_busy) n++;
      else if (n > 0) return;
    end
  endtask

  task automatic do_rd(input int r, input int a, input logic [DATAW-1:0] exp, input string nm);
    bit got = 0;
    rd_vld[r] = 1;
    rd_addr[r*AW +: AW] = AW'(a);
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = rd_gnt[r];
      tick();
    end
    rd_vld[r] = 0;
    @(negedge clk);
    chk(nm, got ? {28'd0, rsp_vld, rsp_data} : 64'hdead, {28'd0, NREQ'(1 << r), exp});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish at time %0t", $time);
    $fatal(1);
  end

  initial begin
    int n, g;
    logic [15:0] word;
    logic [31:0] seq;
    logic [NREQ-1:0] gv, prevg;
    @(negedge clk);
    chk("reset_busy", clr_busy, 0);
    chk("reset_rspv", rsp_vld, 0);
    chk("reset_raddr", mem_raddr, 0);
    tick();
    rst_n = 1;
    tick();
    // full clear after reset
    clr_pulse();
    wait_clear(n);
    chk("clr_len", n, 16);
    tick();
    for (int a = 0; a < MEMD; a++) do_rd(a % NREQ, a, 0, "clr_zero");
    // four held writes
    for (int i = 0; i < NREQ; i++) begin
      wr_addr[i*AW +: AW] = AW'(i);
      wr_data[i*DATAW +: DATAW] = 32'hA0 + i;
    end
    wr_vld = 4'hF;
    word = 16'hFFFF;
    n = 0;
    for (int c = 0; c < 8 && wr_vld != 0; c++) begin
      @(negedge clk);
      gv = wr_gnt;
      if (gv != 0 && n < 4) begin word[n*4 +: 4] = 4'(oh2i(gv)); n++; end
      tick();
      wr_vld &= ~gv;
    end
    wr_vld = 0;
    chk("wr_order", word, 16'h3210);
    for (int a = 0; a < 4; a++) do_rd(a, a, 32'hA0 + a, "wr_readback");
    // all four hold reads for 8 cycles
    for (int i = 0; i < NREQ; i++) rd_addr[i*AW +: AW] = AW'(i);
    rd_vld = 4'hF;
    seq = 0;
    prevg = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      gv = rd_gnt;
      seq[c*4 +: 4] = 4'(oh2i(gv));
      if (c > 0) chk("rsp_trail", rsp_vld, prevg);
      prevg = gv;
      tick();
    end
    rd_vld = 0;
    @(negedge clk);
    chk("rsp_trail_last", {rsp_vld, rsp_data}, {4'b1000, 32'hA3});
    chk("rd_order", seq, 32'h32103210);
    tick();
    // same-cycle write and read of address 5
    wr_vld[1] = 1; wr_addr[1*AW +: AW] = 5; wr_data[1*DATAW +: DATAW] = 32'h55;
    rd_vld[2] = 1; rd_addr[2*AW +: AW] = 5;
    @(negedge clk);
    chk("byp_gnt", {wr_gnt, rd_gnt}, 8'b0010_0100);
    tick();
    wr_vld = 0;
    rd_vld = 0;
    @(negedge clk);
    chk("byp_rsp", {rsp_vld, rsp_data}, {4'b0100, 32'h55});
    tick();
    // clear request collides with a write request
    wr_vld[0] = 1; wr_addr[0*AW +: AW] = 7; wr_data[0*DATAW +: DATAW] = 32'h77;
    clr_req = 1;
    @(negedge clk);
    chk("clr_prio_gnt", wr_gnt, 0);
    tick();
    clr_req = 0;
    wait_clear(n);
    chk("clr_prio_len", n, 16);
    chk("clr_resume_gnt", wr_gnt, 4'b0001);
    tick();
    wr_vld = 0;
    do_rd(3, 7, 32'h77, "clr_resume_data");
    // reset in the middle of a clear
    clr_pulse();
    n = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (clr_busy) n++;
    end
    chk("mid_pre", n, 7);
    tick();
    rst_n = 0;
    #1;
    chk("mid_busy_drop", clr_busy, 0);
    tick();
    rst_n = 1;
    tick();
    clr_pulse();
    wait_clear(n);
    chk("mid_reclear_len", n, 16);
    tick();
    do_rd(0, 5, 0, "reclear_zero5");
    do_rd(1, 7, 0, "reclear_zero7");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dpram_rr_ctrl.md
# dpram_rr_ctrl

Arbiter and sequencer that shares one dual-port RAM (`dpram`, one write port and one registered read port) among NREQ requesters in the Sephirot core. It uses two independent round-robin arbiters, one for the write port and one for the read port, and routes read responses back to the requester that issued them. It also contains a clear engine that zeroes the whole memory on request. The block sits between the execution lanes and a `dpram` instance built with BYPASS=1, which the parent instantiates.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- MEMD, 16: memory depth; must equal the connected `dpram` MEMD.
- DATAW, 32: data width.
- AW, $clog2(MEMD): address width, derived; not to be overridden.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr_req  in  1  single-cycle pulse that starts a clear of the whole memory.
- clr_busy  out  1  high while the clear engine owns the memory.
- wr_vld  in  NREQ  per-requester write request; held until granted.
- wr_addr  in  NREQ*AW  packed write addresses; requester i occupies bits [i*AW +: AW].
- wr_data  in  NREQ*DATAW  packed write data.
- wr_gnt  out  NREQ  one-hot write grant, same cycle as the request.
- rd_vld  in  NREQ  per-requester read request; held until granted.
- rd_addr  in  NREQ*AW  packed read addresses.
- rd_gnt  out  NREQ  one-hot read grant, same cycle as the request.
- rsp_vld  out  NREQ  one-hot read-response valid.
- rsp_data  out  DATAW  read data, shared by all requesters, qualified by rsp_vld.
- mem_wenb / mem_waddr / mem_wdata  out  1/AW/DATAW  drive the `dpram` write port.
- mem_raddr  out  AW  drives the `dpram` read address.
- mem_rdata  in  DATAW  `dpram` RData.

## Operation
- State machine has two states, IDLE and CLEAR. Reset enters IDLE.
- IDLE to CLEAR: on clr_req=1. The clear takes priority over any requests pending in the same cycle; those requests get no grant.
- CLEAR:
  - Drives mem_wenb=1, mem_waddr=clr_cnt, mem_wdata=0.
  - All wr_gnt and rd_gnt are held at 0.
  - clr_cnt increments by 1 each cycle.
  - After the write at address MEMD-1, clr_cnt wraps to 0 and the state returns to IDLE.
  - clr_req is ignored while in CLEAR.
- IDLE write arbitration:
  - Grants the first requester with wr_vld=1, searching from wptr upward modulo NREQ.
  - mem_wenb = |wr_gnt; the granted requester's address and data are muxed onto mem_waddr and mem_wdata.
  - On a grant to requester k, wptr becomes (k+1) mod NREQ. With no grant, wptr is unchanged.
- Read arbitration: identical scheme with its own pointer rptr. mem_raddr carries the granted requester's address; when there is no grant, mem_raddr holds its last value.
- Read response:
  - rd_gnt is registered into rsp_vld, so the response arrives exactly one cycle after the grant.
  - rsp_data = mem_rdata, passed through combinationally.
- Write and read to the same address in the same cycle: the response returns the new data, through the `dpram` BYPASS=1 path. This is required behaviour, not incidental.
- Requesters must hold vld, addr and data stable until granted. The arbiter never drops a held request.

## Timing
- Reset values: clr_busy=0, rsp_vld=0, wptr=rptr=0, clr_cnt=0, state=IDLE. After reset, requester 0 has highest priority.
- wr_gnt, rd_gnt, mem_wenb, mem_waddr, mem_wdata and mem_raddr are combinational from the request inputs and registered state. They are 0 (or hold, for mem_raddr) when there is no request.
- Read latency: one cycle from rd_gnt to rsp_vld.
- Sustained throughput in IDLE: one write and one read per cycle.
- clr_busy:
  - Is registered state (state==CLEAR).
  - Rises the cycle after clr_req and stays high for exactly MEMD cycles.
  - Grants resume the cycle after it falls.
- A read granted in the last IDLE cycle still returns rsp_vld during the first CLEAR cycle.
- Starvation bound: a held request is granted within NREQ arbitration cycles in IDLE.
- rst_n asserted mid-clear: immediate return to IDLE and clr_busy=0. The memory contents are then unspecified.

## Structure
- One sub-module, `rr_arbiter`, with parameter N. Inputs are req[N] and a registered pointer; outputs are a one-hot gnt and the next pointer. It is instantiated twice, once for writes and once for reads.
- Derive AW with the existing clog2 function header. No new shared package.
- State encoding stays as local parameters inside this block.

## Test plan
- Reset followed by clr_req with MEMD=16:
  - clr_busy is high for 16 cycles.
  - Reading addresses 0..15 afterwards returns 0 for each.
- Requesters 0..3 all hold wr_vld to addresses 0..3 with data 0xA0..0xA3:
  - Grants go 0,1,2,3 on consecutive cycles.
  - Reads of addresses 0..3 then return 0xA0..0xA3.
- Requester 2 reads address 5 while requester 1 writes 0x55 to address 5 in the same cycle: rsp_vld[2] arrives next cycle with rsp_data=0x55.
- All four requesters hold rd_vld for 8 cycles: each receives exactly 2 grants in order 0,1,2,3,0,1,2,3, and rsp_vld trails each grant by one cycle.
- clr_req in the same cycle as wr_vld[0]: no grant is issued, the clear runs, and wr_gnt[0] asserts the cycle after clr_busy falls.
- rst_n pulsed low at clear cycle 7: clr_busy drops immediately, and after release a new clr_req runs the full 16 cycles.
